// File: rtl/button_event_fifo_pkg.sv
// Shared widths and helpers for the button event FIFO.
// Defaults match a 4-button, 8-entry build.
package btn_evt_pkg;

    localparam int NUM_BUTTONS_DEF = 4;
    localparam int DEPTH_DEF       = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int CODE_W = clog2(NUM_BUTTONS_DEF);
    localparam int PTR_W  = clog2(DEPTH_DEF);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TS_W   = 16;

endpackage

// File: rtl/button_event_fifo_if.sv
// Pulse inputs and queue outputs of the button event FIFO.
// out_timestamp exists only with BUTTON_EVENT_TIMESTAMP_EN.
interface button_event_fifo_if #(
    parameter int NUM_BUTTONS = btn_evt_pkg::NUM_BUTTONS_DEF,
    parameter int DEPTH       = btn_evt_pkg::DEPTH_DEF
);
    import btn_evt_pkg::*;

    localparam int CW = clog2(NUM_BUTTONS);
    localparam int NW = clog2(DEPTH) + 1;

    logic [NUM_BUTTONS-1:0] in_pulse;
    logic                   in_ready;
    logic                   out_valid;
    logic [CW-1:0]          out_code;
    logic [NW-1:0]          out_count;
    logic                   out_overflow;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0]        out_timestamp;
`endif

    modport master (
        output in_pulse, in_ready,
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        input  out_timestamp,
`endif
        input  out_valid, out_code, out_count, out_overflow
    );

    modport slave (
        input  in_pulse, in_ready,
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        output out_timestamp,
`endif
        output out_valid, out_code, out_count, out_overflow
    );

endinterface

// File: rtl/button_event_fifo_mem.sv
// FIFO storage: synchronous write, registered read at the next head.
// Write-to-read bypass lets a push into an empty queue appear at once.
module btn_evt_fifo_mem #(
    parameter int W     = 2,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/button_event_fifo.sv
// Serializes button press pulses into a FIFO of button indices.
// BUTTON_EVENT_TIMESTAMP_EN adds a 16-bit push timestamp per entry.
module button_event_fifo
    import btn_evt_pkg::*;
#(
    parameter int NUM_BUTTONS = NUM_BUTTONS_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic in_clock,
    input  logic in_reset_n,
    button_event_fifo_if.slave bus
);

    localparam int CW = clog2(NUM_BUTTONS);
    localparam int PW = clog2(DEPTH);
    localparam int NW = PW + 1;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    localparam int EW = CW + TS_W;
`else
    localparam int EW = CW;
`endif

    logic [NUM_BUTTONS-1:0] pend_q, pend_d, grant;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [NW-1:0]          cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   pop, push, push_ok;
    logic [CW-1:0]          gidx;
    logic [EW-1:0]          wdata, rdata;

    always_comb begin
        pop     = (cnt_q != '0) && bus.in_ready;
        push_ok = (cnt_q < NW'(DEPTH)) || pop;
        grant   = '0;
        if (push_ok) grant = pend_q & (~pend_q + NUM_BUTTONS'(1));
        push    = |grant;
        gidx    = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (grant[i]) gidx = CW'(i);
        end
        pend_d = (pend_q & ~grant) | bus.in_pulse;
        // a press on a still-pending button merges and is lost
        ovf_d  = ovf_q | (|(bus.in_pulse & pend_q & ~grant));
        wptr_d = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) cnt_d = cnt_q + NW'(1);
        else if (pop && !push) cnt_d = cnt_q - NW'(1);
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            pend_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = ts_q + TS_W'(1);

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) ts_q <= '0;
        else ts_q <= ts_d;
    end

    assign wdata             = {ts_q, gidx};
    assign bus.out_timestamp = rdata[EW-1:CW];
`else
    assign wdata = gidx;
`endif

    btn_evt_fifo_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk_i   (in_clock),
        .rst_ni  (in_reset_n),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (wdata),
        .raddr_i (rptr_d),
        .rdata_o (rdata)
    );

    assign bus.out_valid    = (cnt_q != '0);
    assign bus.out_code     = rdata[CW-1:0];
    assign bus.out_count    = cnt_q;
    assign bus.out_overflow = ovf_q;

endmodule

// File: tb/tb_button_event_fifo.sv
// Directed bench for button_event_fifo: vector table plus corner sequences.
// Timestamp checks run only with BUTTON_EVENT_TIMESTAMP_EN.
module tb_button_event_fifo;
    import btn_evt_pkg::*;

    localparam int NB = 4;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_event_fifo_if #(.NUM_BUTTONS(NB), .DEPTH(D)) bus ();

    button_event_fifo #(
        .NUM_BUTTONS (NB),
        .DEPTH       (D)
    ) dut (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] pulse;
        logic       ready;
        logic       v;
        logic [1:0] code;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] p, input logic r);
        bus.in_pulse = p;
        bus.in_ready = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0000, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [15:0] t1, t2;
`endif

    initial begin
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'd1, 1'b0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[3]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'd2, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'd3, 1'b0};
        tbl[7]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'd2, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'd1, 1'b0};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[10] = '{4'b0001, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'd1, 1'b0};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};

        do_reset();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.out_count), 32'd0);
        chk("rst_ovf", 32'(bus.out_overflow), 32'd0);
        chk("rst_code", 32'(bus.out_code), 32'd0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].pulse, tbl[i].ready);
            step();
            chk($sformatf("vec%0d_valid", i),
                32'(bus.out_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_count", i),
                32'(bus.out_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_ovf", i),
                32'(bus.out_overflow), 32'(tbl[i].ovf));
            if (tbl[i].v)
                chk($sformatf("vec%0d_code", i),
                    32'(bus.out_code), 32'(tbl[i].code));
        end

        // fill with button 1, then a held pending press and a dropped one
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0010, 1'b0);
            step();
        end
        drive(4'b0000, 1'b0);
        step();
        chk("fill_count", 32'(bus.out_count), 32'd8);
        drive(4'b0010, 1'b0);
        step();
        chk("p9_count", 32'(bus.out_count), 32'd8);
        chk("p9_ovf", 32'(bus.out_overflow), 32'd0);
        drive(4'b0010, 1'b0);
        step();
        chk("p10_ovf", 32'(bus.out_overflow), 32'd1);
        drive(4'b0000, 1'b1);
        step();
        chk("pop_refill_count", 32'(bus.out_count), 32'd8);
        chk("pop_refill_code", 32'(bus.out_code), 32'd1);
        drive(4'b0000, 1'b1);
        step();
        chk("pend_drained_count", 32'(bus.out_count), 32'd7);
        chk("ovf_sticky", 32'(bus.out_overflow), 32'd1);

        // down to 5 entries with presses pending, then reset
        drive(4'b0000, 1'b1);
        step();
        step();
        drive(4'b0110, 1'b0);
        step();
        chk("pre_rst_count", 32'(bus.out_count), 32'd5);
        rst_n = 1'b0;
        drive(4'b0000, 1'b0);
        step();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.out_count), 32'd0);
        chk("mid_rst_ovf", 32'(bus.out_overflow), 32'd0);
        chk("mid_rst_code", 32'(bus.out_code), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0000, 1'b1);
            step();
            chk($sformatf("post_rst%0d_valid", i),
                32'(bus.out_valid), 32'd0);
        end
        chk("post_rst_count", 32'(bus.out_count), 32'd0);

        // full queue streaming: pop and push every cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0001, 1'b0);
            step();
        end
        drive(4'b0100, 1'b0);
        step();
        chk("stream_full", 32'(bus.out_count), 32'd8);
        for (int k = 1; k <= 12; k++) begin
            drive(4'b0100, 1'b1);
            step();
            chk($sformatf("stream%0d_count", k),
                32'(bus.out_count), 32'd8);
            chk($sformatf("stream%0d_code", k),
                32'(bus.out_code), (k >= 8) ? 32'd2 : 32'd0);
        end
        chk("stream_ovf", 32'(bus.out_overflow), 32'd0);
        drive(4'b0000, 1'b0);

`ifdef BUTTON_EVENT_TIMESTAMP_EN
        do_reset();
        drive(4'b0001, 1'b0);
        step();
        drive(4'b0000, 1'b0);
        repeat (99) step();
        drive(4'b0001, 1'b0);
        step();
        drive(4'b0000, 1'b0);
        step();
        step();
        chk("ts_count", 32'(bus.out_count), 32'd2);
        t1 = bus.out_timestamp;
        drive(4'b0000, 1'b1);
        step();
        drive(4'b0000, 1'b0);
        t2 = bus.out_timestamp;
        chk("ts_delta", 32'(16'(t2 - t1)), 32'd100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
